// File: rtl/tlp_tx_framer.sv
// PCIe TX framer: arbitrates register completions against DMA writes and emits
// 64-bit Avalon-ST TLP beats (header QWs, then payload) with SOP/EOP framing.
module tlp_tx_framer #(
  parameter int MAX_PAYLOAD_QW = 16,
  parameter int ADDR64_EN      = 1
) (
  input  logic        pcieClk_in,
  input  logic        pcieRstN_in,
  input  logic [15:0] cfgBusID_in,
  input  logic        cmpValid_in,
  output logic        cmpReady_out,
  input  logic [15:0] cmpReqID_in,
  input  logic [7:0]  cmpTag_in,
  input  logic [3:0]  cmpLowAddr_in,
  input  logic [31:0] cmpData_in,
  input  logic        dmaValid_in,
  output logic        dmaReady_out,
  input  logic [63:0] dmaAddr_in,
  input  logic [9:0]  dmaQWCount_in,
  input  logic        dmaDataValid_in,
  output logic        dmaDataReady_out,
  input  logic [63:0] dmaData_in,
  output logic [63:0] txData_out,
  output logic        txValid_out,
  output logic        txSop_out,
  output logic        txEop_out,
  input  logic        txReady_in,
  output logic        errPulse_out
);

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

  localparam logic [1:0]  FMT_H3DW_WITHDATA = 2'b10;
  localparam logic [1:0]  FMT_H4DW_WITHDATA = 2'b11;
  localparam logic [4:0]  TYPE_MEM_RW_REQ   = 5'b00000;
  localparam logic [4:0]  TYPE_COMPLETION   = 5'b01010;
  localparam logic [10:0] MAX_QW            = 11'(MAX_PAYLOAD_QW);

  state_t      state;
  logic        cmp_prio;
  logic        armed;
  logic        is_dma;
  logic [9:0]  qw_left;
  logic [63:0] hdr0_q;
  logic [63:0] hdr1_q;

  logic        slot_free;
  logic        req_idle;
  logic        cmp_win;
  logic        dma_win;
  logic        dma_bad;
  logic        addr_hi;
  logic [31:0] addr_lo;
  logic [63:0] new_hdr0;
  logic [63:0] new_hdr1;
  logic        unused_addr_bits;

  // The output register may be (re)loaded when it is empty or its beat leaves now.
  assign slot_free = !txValid_out || txReady_in;
  // armed keeps every handshake closed until the first edge after reset release.
  assign req_idle  = armed && (state == IDLE);
  assign cmp_win   = req_idle && cmpValid_in && (cmp_prio || !dmaValid_in);
  assign dma_win   = req_idle && dmaValid_in && (!cmp_prio || !cmpValid_in);

  assign cmpReady_out     = cmp_win;
  assign dmaReady_out     = dma_win;
  assign dmaDataReady_out = (state == DATA) && slot_free;

  assign dma_bad = (dmaQWCount_in == 10'd0) || ({1'b0, dmaQWCount_in} > MAX_QW);
  assign addr_hi = (ADDR64_EN != 0) && (dmaAddr_in[63:32] != 32'h0);
  assign addr_lo = {dmaAddr_in[31:3], 3'b000};
  assign unused_addr_bits = ^dmaAddr_in[2:0];

  // Header QWs for whichever request wins this cycle; DW0 sits in the lower half.
  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    new_hdr0 = {cfgBusID_in, 3'b000, 1'b0, 12'd4,
                1'b0, FMT_H3DW_WITHDATA, TYPE_COMPLETION, 14'h0, 10'd1};
    new_hdr1 = {cmpData_in, cmpReqID_in, cmpTag_in, 1'b0, cmpLowAddr_in, 1'b1, 2'b00};
    if (dma_win) begin
      new_hdr0 = {cfgBusID_in, 8'h00, 4'hF, 4'hF,
                  1'b0, addr_hi ? FMT_H4DW_WITHDATA : FMT_H3DW_WITHDATA,
                  TYPE_MEM_RW_REQ, 14'h0, {dmaQWCount_in[8:0], 1'b0}};
      new_hdr1 = addr_hi ? {addr_lo, dmaAddr_in[63:32]} : {32'h0, addr_lo};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the
  // same edge override the default "drain" of the output register.
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      // NOTE: header and data registers are reset as well, so every output reads 0 during reset.
      state        <= IDLE;
      cmp_prio     <= 1'b1;
      armed        <= 1'b0;
      is_dma       <= 1'b0;
      qw_left      <= '0;
      hdr0_q       <= '0;
      hdr1_q       <= '0;
      txData_out   <= '0;
      txValid_out  <= 1'b0;
      txSop_out    <= 1'b0;
      txEop_out    <= 1'b0;
      errPulse_out <= 1'b0;
    end else begin
      armed        <= 1'b1;
      errPulse_out <= 1'b0;
      if (slot_free) begin
        txValid_out <= 1'b0;
        txSop_out   <= 1'b0;
        txEop_out   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cmp_win || dma_win) begin
            cmp_prio <= dma_win;
            if (dma_win && dma_bad) begin
              errPulse_out <= 1'b1;
            end else begin
              hdr0_q  <= new_hdr0;
              hdr1_q  <= new_hdr1;
              is_dma  <= dma_win;
              qw_left <= dmaQWCount_in;
              if (slot_free) begin
                txData_out  <= new_hdr0;
                txValid_out <= 1'b1;
                txSop_out   <= 1'b1;
                state       <= HDR1;
              end else begin
                state <= HDR0;
              end
            end
          end
        end
        HDR0: begin
          if (slot_free) begin
            txData_out  <= hdr0_q;
            txValid_out <= 1'b1;
            txSop_out   <= 1'b1;
            state       <= HDR1;
          end
        end
        HDR1: begin
          if (slot_free) begin
            txData_out  <= hdr1_q;
            txValid_out <= 1'b1;
            txEop_out   <= !is_dma;
            state       <= is_dma ? DATA : IDLE;
          end
        end
        DATA: begin
          if (dmaDataValid_in && slot_free) begin
            txData_out  <= dmaData_in;
            txValid_out <= 1'b1;
            txEop_out   <= (qw_left == 10'd1);
            qw_left     <= qw_left - 10'd1;
            if (qw_left == 10'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_tx_framer.sv
// Directed bench for tlp_tx_framer: expected TX beats are queued when a request is
// driven and compared as the framer transfers them.
module tb_tlp_tx_framer;

  localparam logic [15:0] BUS_ID = 16'h0A01;

  logic        clk;
  logic        rst_n;
  logic        cmp_valid, cmp_ready;
  logic [15:0] cmp_req_id;
  logic [7:0]  cmp_tag;
  logic [3:0]  cmp_low_addr;
  logic [31:0] cmp_data;
  logic        dma_valid, dma_ready;
  logic [63:0] dma_addr;
  logic [9:0]  dma_qw;
  logic        dma_data_valid, dma_data_ready;
  logic [63:0] dma_data;
  logic [63:0] tx_data;
  logic        tx_valid, tx_sop, tx_eop, tx_ready;
  logic        err_pulse;

  int checks = 0;
  int failures = 0;
  int beat_cnt = 0;
  int err_cnt = 0;
  logic [65:0] exp_q[$];
  logic [63:0] pay_q[$];
  logic        data_fire = 1'b0;
  logic        ready_toggle = 1'b0;
  logic        held = 1'b0;
  logic [66:0] held_val = '0;

  tlp_tx_framer #(.MAX_PAYLOAD_QW(16), .ADDR64_EN(1)) dut (
    .pcieClk_in(clk), .pcieRstN_in(rst_n), .cfgBusID_in(BUS_ID),
    .cmpValid_in(cmp_valid), .cmpReady_out(cmp_ready), .cmpReqID_in(cmp_req_id),
    .cmpTag_in(cmp_tag), .cmpLowAddr_in(cmp_low_addr), .cmpData_in(cmp_data),
    .dmaValid_in(dma_valid), .dmaReady_out(dma_ready), .dmaAddr_in(dma_addr),
    .dmaQWCount_in(dma_qw), .dmaDataValid_in(dma_data_valid),
    .dmaDataReady_out(dma_data_ready), .dmaData_in(dma_data),
    .txData_out(tx_data), .txValid_out(tx_valid), .txSop_out(tx_sop),
    .txEop_out(tx_eop), .txReady_in(tx_ready), .errPulse_out(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] cmp_hdr0();
    return {BUS_ID, 3'b000, 1'b0, 12'd4, 1'b0, 2'b10, 5'b01010, 14'h0, 10'd1};
  endfunction

  function automatic logic [63:0] cmp_hdr1(logic [15:0] rid, logic [7:0] tag,
                                            logic [3:0] la, logic [31:0] d);
    return {d, rid, tag, 1'b0, la, 1'b1, 2'b00};
  endfunction

  function automatic logic [63:0] dma_hdr0(logic [63:0] a, int qw);
    logic [9:0] dw;
    dw = 10'((qw * 2) % 1024);
    return {BUS_ID, 8'h00, 8'hFF, 1'b0, (a[63:32] != 0) ? 2'b11 : 2'b10, 5'b00000, 14'h0, dw};
  endfunction

  function automatic logic [63:0] dma_hdr1(logic [63:0] a);
    if (a[63:32] != 0) return {a[31:3], 3'b000, a[63:32]};
    return {32'h0, a[31:3], 3'b000};
  endfunction

  task automatic push_exp(input logic [63:0] d, input logic sop, input logic eop);
    exp_q.push_back({sop, eop, d});
  endtask

  task automatic wait_accept(input bit is_dma, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (is_dma ? dma_ready : cmp_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    check(tag, 67'(ok), 67'd1);
  endtask

  task automatic do_cmp(input logic [15:0] rid, input logic [7:0] tag,
                        input logic [3:0] la, input logic [31:0] d);
    push_exp(cmp_hdr0(), 1'b1, 1'b0);
    push_exp(cmp_hdr1(rid, tag, la, d), 1'b0, 1'b1);
    cmp_req_id = rid; cmp_tag = tag; cmp_low_addr = la; cmp_data = d;
    cmp_valid = 1'b1;
    wait_accept(1'b0, "cmp_accept");
    cmp_valid = 1'b0;
    cmp_req_id = ~rid; cmp_tag = ~tag; cmp_low_addr = ~la; cmp_data = ~d;
  endtask

  task automatic do_dma(input logic [63:0] a, input int qw, input logic [63:0] base,
                        input bit feed);
    push_exp(dma_hdr0(a, qw), 1'b1, 1'b0);
    push_exp(dma_hdr1(a), 1'b0, 1'b0);
    for (int i = 0; i < qw; i++) begin
      push_exp(base + 64'(i), 1'b0, (i == qw - 1));
      if (feed) pay_q.push_back(base + 64'(i));
    end
    dma_addr = a; dma_qw = 10'(qw); dma_valid = 1'b1;
    wait_accept(1'b1, "dma_accept");
    dma_valid = 1'b0; dma_addr = ~a; dma_qw = 10'd3;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
    check(tag, 67'(exp_q.size()), 67'd0);
    #1;
  endtask

  // Payload source and TX back-pressure, updated just after each rising edge.
  initial begin
    tx_ready = 1'b1;
    dma_data_valid = 1'b0;
    dma_data = '0;
    forever begin
      @(posedge clk);
      if (data_fire && pay_q.size() != 0) void'(pay_q.pop_front());
      #1;
      tx_ready = ready_toggle ? ~tx_ready : 1'b1;
      dma_data_valid = (pay_q.size() != 0);
      dma_data = (pay_q.size() != 0) ? pay_q[0] : 64'h0;
    end
  end

  // Monitor: on each falling edge, decide what the next rising edge will transfer.
  initial begin
    forever begin
      @(negedge clk);
      data_fire = dma_data_valid && dma_data_ready;
      if (err_pulse) err_cnt++;
      if (rst_n) begin
        if (held) check("stall_hold", {tx_valid, tx_sop, tx_eop, tx_data}, held_val);
        held = tx_valid && !tx_ready;
        held_val = {tx_valid, tx_sop, tx_eop, tx_data};
        if (tx_valid && tx_ready) begin
          beat_cnt++;
          checks++;
          assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL beat_unexpected: observed=%h expected=none", {tx_sop, tx_eop, tx_data});
          end
          if (exp_q.size() != 0)
            check($sformatf("beat%0d", beat_cnt), {1'b0, tx_sop, tx_eop, tx_data},
                  {1'b0, exp_q.pop_front()});
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int ncmp, ndma, err0, beat0;
    logic c, d;

    // Reset with a completion already pending: nothing may be accepted early.
    rst_n = 1'b0;
    cmp_valid = 1'b0; dma_valid = 1'b0;
    dma_addr = '0; dma_qw = '0;
    push_exp(cmp_hdr0(), 1'b1, 1'b0);
    push_exp(cmp_hdr1(16'h0100, 8'h05, 4'h4, 32'hDEADBEEF), 1'b0, 1'b1);
    cmp_req_id = 16'h0100; cmp_tag = 8'h05; cmp_low_addr = 4'h4; cmp_data = 32'hDEADBEEF;
    cmp_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 67'({tx_valid, tx_sop, tx_eop, cmp_ready, dma_ready, dma_data_ready, err_pulse}), '0);
    check("rst_data", 67'(tx_data), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_first_edge", 67'(cmp_ready), '0);
    wait_accept(1'b0, "cmp_accept_first");
    cmp_valid = 1'b0;
    cmp_req_id = 16'hFFFF; cmp_tag = 8'hAA; cmp_low_addr = 4'hB; cmp_data = 32'h1234_5678;
    @(negedge clk);
    check("latency1_valid_sop", 67'({tx_valid, tx_sop}), 67'b11);
    drain("drain_cmp_first");

    // 3DW DMA write, 4 QWs.
    do_dma(64'h0000_0000_1000_0000, 4, 64'hA5A5_0000_0000_0000, 1'b1);
    drain("drain_dma_3dw");

    // 4DW DMA write whose payload arrives late: the stream starves first.
    do_dma(64'h0000_0001_0000_0000, 2, 64'hB0B0_0000_0000_0010, 1'b0);
    repeat (4) @(negedge clk);
    check("starve_valid", 67'(tx_valid), '0);
    check("starve_data_ready", 67'(dma_data_ready), 67'd1);
    @(posedge clk); #1;
    pay_q.push_back(64'hB0B0_0000_0000_0010);
    pay_q.push_back(64'hB0B0_0000_0000_0011);
    drain("drain_dma_4dw");

    // Both requesters held high: grants must alternate CMP, DMA, CMP, DMA.
    push_exp(cmp_hdr0(), 1'b1, 1'b0);
    push_exp(cmp_hdr1(16'h0222, 8'h33, 4'hC, 32'hCAFE_F00D), 1'b0, 1'b1);
    push_exp(dma_hdr0(64'h0000_0000_0000_8008, 1), 1'b1, 1'b0);
    push_exp(dma_hdr1(64'h0000_0000_0000_8008), 1'b0, 1'b0);
    push_exp(64'hC1C1_C1C1_C1C1_C1C1, 1'b0, 1'b1);
    push_exp(cmp_hdr0(), 1'b1, 1'b0);
    push_exp(cmp_hdr1(16'h0222, 8'h33, 4'hC, 32'hCAFE_F00D), 1'b0, 1'b1);
    push_exp(dma_hdr0(64'h0000_0000_0000_8008, 1), 1'b1, 1'b0);
    push_exp(dma_hdr1(64'h0000_0000_0000_8008), 1'b0, 1'b0);
    push_exp(64'hC2C2_C2C2_C2C2_C2C2, 1'b0, 1'b1);
    pay_q.push_back(64'hC1C1_C1C1_C1C1_C1C1);
    pay_q.push_back(64'hC2C2_C2C2_C2C2_C2C2);
    cmp_req_id = 16'h0222; cmp_tag = 8'h33; cmp_low_addr = 4'hC; cmp_data = 32'hCAFE_F00D;
    dma_addr = 64'h0000_0000_0000_8008; dma_qw = 10'd1;
    cmp_valid = 1'b1; dma_valid = 1'b1;
    ncmp = 0; ndma = 0;
    for (int i = 0; i < 200 && (ncmp < 2 || ndma < 2); i++) begin
      @(negedge clk);
      c = cmp_ready; d = dma_ready;
      check("arb_one_grant", 67'(c && d), '0);
      @(posedge clk); #1;
      if (c) begin ncmp++; if (ncmp == 2) cmp_valid = 1'b0; end
      if (d) begin ndma++; if (ndma == 2) dma_valid = 1'b0; end
    end
    check("arb_cmp_grants", 67'(ncmp), 67'd2);
    check("arb_dma_grants", 67'(ndma), 67'd2);
    drain("drain_arb");

    // 16-QW write with TX ready toggling every cycle.
    ready_toggle = 1'b1;
    do_dma(64'h0000_0000_3000_0040, 16, 64'hD000_0000_0000_0100, 1'b1);
    drain("drain_toggle");
    ready_toggle = 1'b0;
    @(posedge clk); #1;

    // Illegal lengths: accepted, dropped, one error pulse each, no TX beats.
    err0 = err_cnt; beat0 = beat_cnt;
    dma_addr = 64'h0000_0000_4000_0000; dma_qw = 10'd0; dma_valid = 1'b1;
    wait_accept(1'b1, "drop0_accept");
    dma_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    dma_qw = 10'd17; dma_valid = 1'b1;
    wait_accept(1'b1, "drop17_accept");
    dma_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("drop_err_pulses", 67'(err_cnt - err0), 67'd2);
    check("drop_no_beats", 67'(beat_cnt - beat0), '0);

    // Reset while DATA beat 2 of an 8-QW write is on the bus.
    do_dma(64'h0000_0000_5000_0000, 8, 64'hE000_0000_0000_0200, 1'b1);
    for (int i = 0; i < 200 && exp_q.size() > 6; i++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", 67'({tx_valid, tx_sop, tx_eop, cmp_ready, dma_ready, dma_data_ready, err_pulse}), '0);
    check("midrst_data", 67'(tx_data), '0);
    exp_q.delete();
    pay_q.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    do_cmp(16'h0777, 8'hFE, 4'h8, 32'h0BAD_CAFE);
    drain("drain_after_rst");
    check("payload_consumed", 67'(pay_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlp_tx_framer.md
TLP_TX_FRAMER -- requirements
Module: tlp_tx_framer

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD_QW, default 16, maximum DMA-write payload in QWs (legal range 1..512).
REQ-002 SHALL have parameter ADDR64_EN, default 1; 1 enables 4DW-header writes, 0 forces 3DW.
REQ-003 pcieClk_in  in  1  sole clock; all state changes on its rising edge.
REQ-004 pcieRstN_in  in  1  asynchronous, active-low reset.
REQ-005 cfgBusID_in  in  16  own BusID, used as completer/requester ID.
REQ-006 cmpValid_in / cmpReady_out  in/out  1/1  register-completion request handshake.
REQ-007 cmpReqID_in, cmpTag_in, cmpLowAddr_in, cmpData_in  in  16/8/4/32  completion fields.
REQ-008 dmaValid_in / dmaReady_out  in/out  1/1  DMA-write request handshake.
REQ-009 dmaAddr_in  in  64  QW-aligned byte address (bits[2:0] ignored).
REQ-010 dmaQWCount_in  in  10  payload length in QWs.
REQ-011 dmaDataValid_in / dmaDataReady_out  in/out  1/1  payload stream handshake; dmaData_in  in  64.
REQ-012 txData_out  out  64; txValid_out, txSop_out, txEop_out  out  1 each; txReady_in  in  1  Avalon-ST TX.
REQ-013 errPulse_out  out  1  one-cycle pulse on a dropped illegal DMA request.

Function
REQ-014 A TX beat SHALL transfer when txValid_out & txReady_in; while txValid_out=1 and txReady_in=0, txData/Sop/Eop SHALL hold stable.
REQ-015 SHALL be a state machine IDLE -> HDR0 -> HDR1 -> (DATA ->) IDLE; HDR0 carries QW0 (DW0 lower, DW1 upper), txSop_out=1.
REQ-016 In IDLE, cmpReady_out / dmaReady_out SHALL assert only for the arbitration winner; both deassert outside IDLE.
REQ-017 Arbitration SHALL alternate when both requests are pending; a lone requester always wins; after reset the completion wins first.
REQ-018 First header beat SHALL be valid the cycle after request acceptance (latency 1); no idle cycles between beats of one TLP when txReady_in and dmaDataValid_in stay high.
REQ-019 Completion: fmt=H3DW_WITHDATA, type=COMPLETION, dwCount=1, status=0, byteCount=4, cmpID=cfgBusID_in; HDR1 lower DW = {reqID, tag, 0, lowAddr, nonAligned=1, 00}, upper DW = cmpData_in; txEop_out=1 on HDR1; 2 beats total.
REQ-020 DMA write header: type=MEM_RW_REQ, firstBE=lastBE=4'hF, reqID=cfgBusID_in, dwCount=2*dmaQWCount_in mod 1024 (512 QWs encodes as 0).
REQ-021 If ADDR64_EN=1 and dmaAddr_in[63:32]!=0: fmt=H4DW_WITHDATA, HDR1 = {addr[31:0], addr[63:32]} (upper, lower); otherwise fmt=H3DW_WITHDATA, HDR1 = {32'h0 pad, addr[31:0]}.
REQ-022 DATA state SHALL forward one dmaData_in QW per beat, dmaDataReady_out = txReady_in or no beat held; txValid_out deasserts when stream starved; txEop_out on the dmaQWCount_in-th QW.
REQ-023 Request fields SHALL be latched at acceptance; later input changes do not affect an in-flight TLP.
REQ-024 dmaQWCount_in=0 or >MAX_PAYLOAD_QW: request accepted, nothing transmitted, errPulse_out=1 for one cycle, return to IDLE next cycle.
REQ-025 dmaDataReady_out SHALL be 0 outside DATA state; no payload consumed for completions or dropped requests.

Reset
REQ-026 On pcieRstN_in=0 (any time, mid-packet included): state IDLE, arbitration pointer to completion, all outputs 0; a partial TLP is abandoned, not resumed.
REQ-027 First acceptance SHALL occur no earlier than the first clock edge after reset deassertion.

Verification
REQ-028 Completion reqID=16'h0100, tag=8'h05, lowAddr=4'h4, data=32'hDEADBEEF, txReady=1 -> 2 beats, Sop on beat0, Eop on beat1, beat1 upper DW=32'hDEADBEEF.
REQ-029 DMA addr=64'h0000_0000_1000_0000, 4 QWs -> 3DW fmt 2'b10, dwCount=8, 6 beats, Eop on beat 5; addr=64'h1_0000_0000 -> fmt 2'b11, beat1=64'h0000_0000_0000_0001.
REQ-030 cmpValid and dmaValid both held high for 4 TLPs -> order CMP, DMA, CMP, DMA.
REQ-031 txReady_in toggling 1/0 every cycle during a 16-QW write -> all 18 beats delivered in order, outputs stable while stalled.
REQ-032 dmaQWCount_in=0, then 17 (MAX=16) -> two errPulse_out pulses, no txValid_out.
REQ-033 Reset asserted on DATA beat 2 of an 8-QW write -> all outputs 0 immediately; next completion transmits cleanly.
